// File: rtl/rv_arb_pkg.sv
// rtl/rv_arb_pkg.sv - shared state type, constants and round-robin pick for rv_rr_arbiter
package rv_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int SKID_DEPTH = 2;
   localparam int MAX_REQ    = 16;
   localparam int REQ_IDW    = 4;

   // Winner is the first valid index after last_grant, wrapping at num_req.
   // An excluded index only wins when nothing else is valid.
   function automatic logic [REQ_IDW-1:0] rr_pick(
      input logic [MAX_REQ-1:0] valid_vec,
      input logic [REQ_IDW-1:0] last_grant,
      input logic               exclude_en,
      input logic [REQ_IDW-1:0] exclude_id,
      input int                 num_req
   );
      logic [REQ_IDW-1:0] pick;
      logic [REQ_IDW-1:0] idx;
      logic               found;
      pick  = last_grant;
      found = 1'b0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         idx = REQ_IDW'((int'(last_grant) + k) % num_req);
         if (k <= num_req && !found && valid_vec[idx] &&
             !(exclude_en && idx == exclude_id)) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      if (!found && exclude_en && valid_vec[exclude_id]) begin
         pick = exclude_id;
      end
      return pick;
   endfunction

endpackage

// File: rtl/rv_skid_buffer.sv
// rtl/rv_skid_buffer.sv - 2-entry registered ready/valid slice, FIFO order
module rv_skid_buffer
   import rv_arb_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              iclk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] push_tdata,
   input  logic              push_tvalid,
   output logic              push_tready,
   output logic [DATA_W-1:0] pop_tdata,
   output logic              pop_tvalid,
   input  logic              pop_tready
);

   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;
   logic [1:0]        count_q, count_d;
   logic              push_fire;
   logic              pop_fire;

   // Ready depends only on registered occupancy, so no path from pop_tready.
   assign push_tready = (count_q != 2'(SKID_DEPTH));
   assign pop_tvalid  = (count_q != 2'd0);
   assign pop_tdata   = head_q;
   assign push_fire   = push_tvalid && push_tready;
   assign pop_fire    = pop_tvalid && pop_tready;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push_fire, pop_fire})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d = push_tdata;
            end else begin
               tail_d = push_tdata;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            if (count_q == 2'd2) begin
               head_d = tail_q;
            end
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = push_tdata;
            end else begin
               head_d = tail_q;
               tail_d = push_tdata;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge iclk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/rv_rr_arbiter.sv
// rtl/rv_rr_arbiter.sv - burst-bounded round-robin arbiter onto one ready/valid byte channel
module rv_rr_arbiter
   import rv_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                             iclk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]   s_data,
   input  logic [NUM_REQ-1:0]               s_master_valid,
   output logic [NUM_REQ-1:0]               s_slave_ready,
   output logic [DATA_W-1:0]                m_data,
   output logic                             m_master_valid,
   input  logic                             m_slave_ready,
   output logic [$clog2(NUM_REQ)-1:0]       grant_id,
   output logic                             grant_active
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int BCW = $clog2(MAX_BURST + 1);

   arb_state_e     state_q;
   logic [IDW-1:0] grant_id_q;
   logic [IDW-1:0] last_grant_q;
   logic [BCW-1:0] burst_cnt_q;

   logic           buf_ready;
   logic           grantee_valid;
   logic           accept;
   logic           grant_end;
   logic           any_valid;
   logic [IDW-1:0] pick_idle;
   logic [IDW-1:0] pick_next;

   assign any_valid     = |s_master_valid;
   assign grantee_valid = s_master_valid[grant_id_q];
   assign accept        = (state_q == GRANT) && buf_ready && grantee_valid;
   assign grant_end     = (state_q == GRANT) &&
                          (!grantee_valid || (accept && burst_cnt_q == BCW'(MAX_BURST - 1)));

   assign pick_idle = IDW'(rr_pick(MAX_REQ'(s_master_valid), REQ_IDW'(last_grant_q),
                                   1'b0, '0, NUM_REQ));
   // On handover the outgoing grantee is skipped unless it is the only requester.
   assign pick_next = IDW'(rr_pick(MAX_REQ'(s_master_valid), REQ_IDW'(grant_id_q),
                                   1'b1, REQ_IDW'(grant_id_q), NUM_REQ));

   always_ff @(posedge iclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_grant_q <= IDW'(NUM_REQ - 1);
         burst_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_valid) begin
                  state_q     <= GRANT;
                  grant_id_q  <= pick_idle;
                  burst_cnt_q <= '0;
               end
            end
            GRANT: begin
               if (grant_end) begin
                  last_grant_q <= grant_id_q;
                  burst_cnt_q  <= '0;
                  if (any_valid) begin
                     grant_id_q <= pick_next;
                  end else begin
                     state_q <= IDLE;
                  end
               end else if (accept) begin
                  burst_cnt_q <= burst_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      s_slave_ready = '0;
      if (state_q == GRANT && buf_ready) begin
         s_slave_ready[grant_id_q] = 1'b1;
      end
   end

   assign grant_id     = grant_id_q;
   assign grant_active = (state_q == GRANT);

   rv_skid_buffer #(
      .DATA_W (DATA_W)
   ) u_skid (
      .iclk        (iclk),
      .rst_n       (rst_n),
      .push_tdata  (s_data[grant_id_q]),
      .push_tvalid ((state_q == GRANT) && grantee_valid),
      .push_tready (buf_ready),
      .pop_tdata   (m_data),
      .pop_tvalid  (m_master_valid),
      .pop_tready  (m_slave_ready)
   );

endmodule
